// File: rtl/pipe_pkg.sv
// Shared helpers for the pipeline register chain: edge selection constants,
// ceiling log2 for counter sizing, and valid-bit population count.
package pipe_pkg;

  localparam bit EDGE_RISE = 1'b1;
  localparam bit EDGE_FALL = 1'b0;

  // Widest valid vector popcount accepts; deeper chains need this raised.
  localparam int MAX_DEPTH = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data+valid pipeline register with async clear/preset; the capture edge
// is fixed at elaboration, so only one flop variant exists per instance.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int NrOfBits    = 32,
  parameter bit ActiveLevel = EDGE_RISE
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  input  logic                load,
  input  logic                kill,
  input  logic [NrOfBits-1:0] d,
  input  logic                dv,
  output logic [NrOfBits-1:0] q,
  output logic                qv
);

  logic [NrOfBits-1:0] r_q;
  logic                r_qv;

  // kill only clears the valid bit; the data word is left for inspection.
  if (ActiveLevel == EDGE_RISE) begin : g_rise
    always_ff @(posedge Clock or posedge Reset or posedge pre) begin
      if (Reset) begin
        r_q  <= '0;
        r_qv <= 1'b0;
      end else if (pre) begin
        r_q  <= '1;
        r_qv <= 1'b0;
      end else if (kill) begin
        r_qv <= 1'b0;
      end else if (load) begin
        r_q  <= d;
        r_qv <= dv;
      end
    end
  end else begin : g_fall
    always_ff @(negedge Clock or posedge Reset or posedge pre) begin
      if (Reset) begin
        r_q  <= '0;
        r_qv <= 1'b0;
      end else if (pre) begin
        r_q  <= '1;
        r_qv <= 1'b0;
      end else if (kill) begin
        r_qv <= 1'b0;
      end else if (load) begin
        r_q  <= d;
        r_qv <= dv;
      end
    end
  end

  assign q  = r_q;
  assign qv = r_qv;

endmodule

// File: rtl/pipe_reg_chain.sv
// Depth-stage pipeline register with stall/flush, per-stage valid tracking,
// an in-flight valid count for the hazard unit, and a tri-stated output.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int NrOfBits    = 32,
  parameter int Depth       = 1,
  parameter bit ActiveLevel = EDGE_RISE,
  parameter int CntBits     = clog2(Depth + 1)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [NrOfBits-1:0] D,
  input  logic                DValid,
  input  logic                cs,
  output wire logic [NrOfBits-1:0] Q,
  output wire logic                QValid,
  output logic [CntBits-1:0]  Count
);

  logic                w_en;
  logic                w_load;
  logic                w_kill;
  logic [NrOfBits-1:0] w_din  [Depth];
  logic [NrOfBits-1:0] w_data [Depth];
  logic [Depth-1:0]    w_vin;
  logic [Depth-1:0]    w_vld;

  // Flush wins over Stall; a stalled flush still drops the incoming word.
  assign w_en   = ClockEnable & Tick;
  assign w_kill = w_en & Flush;
  assign w_load = w_en & ~Stall & ~Flush;

  assign w_din[0] = D;
  assign w_vin[0] = DValid;

  for (genvar i = 1; i < Depth; i++) begin : g_link
    assign w_din[i] = w_data[i-1];
    assign w_vin[i] = w_vld[i-1];
  end

  for (genvar i = 0; i < Depth; i++) begin : g_stage
    pipe_stage #(
      .NrOfBits    (NrOfBits),
      .ActiveLevel (ActiveLevel)
    ) u_stage (
      .Clock (Clock),
      .Reset (Reset),
      .pre   (pre),
      .load  (w_load),
      .kill  (w_kill),
      .d     (w_din[i]),
      .dv    (w_vin[i]),
      .q     (w_data[i]),
      .qv    (w_vld[i])
    );
  end

  // Derived only from the stage flops, so it tracks them exactly.
  assign Count = CntBits'(popcount(MAX_DEPTH'(w_vld)));

  assign Q      = cs ? {NrOfBits{1'bz}} : w_data[Depth-1];
  assign QValid = cs ? 1'bz : w_vld[Depth-1];

endmodule
